// File: rtl/key_pkg.sv
// Shared definitions for the 4x4 keypad scanner.
//   KEY_* constants  : key codes with a fixed meaning
//   res_kind_e       : frame-result classification
//   frame_res_t      : one complete scan-frame result (kind + code)
//   key_code()       : (row index, column index) -> key code
package key_pkg;

  localparam logic [3:0] KEY_NONE = 4'hF;
  localparam logic [3:0] KEY_DP   = 4'hA;
  localparam logic [3:0] KEY_CLR  = 4'hB;

  typedef enum logic [1:0] {
    RES_NONE   = 2'd0,
    RES_SINGLE = 2'd1,
    RES_MULTI  = 2'd2
  } res_kind_e;

  // code is KEY_NONE for NONE/MULTI so whole-struct compares are meaningful
  typedef struct packed {
    res_kind_e  kind;
    logic [3:0] code;
  } frame_res_t;

  // Keymap; position (3,3) is unpopulated and reads as no key
  function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    case ({r, c})
      4'b00_00: code = 4'h1;
      4'b00_01: code = 4'h2;
      4'b00_10: code = 4'h3;
      4'b00_11: code = KEY_DP;
      4'b01_00: code = 4'h4;
      4'b01_01: code = 4'h5;
      4'b01_10: code = 4'h6;
      4'b01_11: code = KEY_CLR;
      4'b10_00: code = 4'h7;
      4'b10_01: code = 4'h8;
      4'b10_10: code = 4'h9;
      4'b10_11: code = 4'hC;
      4'b11_00: code = 4'hD;
      4'b11_01: code = 4'h0;
      4'b11_10: code = 4'hE;
      default:  code = KEY_NONE;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Frame-level debouncer and press/release state machine.
//   clk, rst      : clock, async active-high reset
//   res_i         : result of the frame that just completed
//   strobe_i      : one-cycle frame-end strobe qualifying res_i
//   key_o         : accepted key code, KEY_NONE when released
//   pressed_o     : high while a debounced key is held
//   key_valid_o   : one-cycle pulse on each accepted new press
module key_debounce
  import key_pkg::*;
#(
  parameter int unsigned DEBOUNCE_FRAMES = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  frame_res_t res_i,
  input  logic       strobe_i,
  output logic [3:0] key_o,
  output logic       pressed_o,
  output logic       key_valid_o
);

  localparam int unsigned SC_W = $clog2(DEBOUNCE_FRAMES + 1);

  typedef enum logic {
    ST_RELEASED = 1'b0,
    ST_PRESSED  = 1'b1
  } state_e;

  state_e     state_q, state_d;
  frame_res_t cand_q, cand_d;
  logic [SC_W-1:0] stable_cnt_q, stable_cnt_d;
  logic [3:0] key_q, key_d;
  logic       pressed_q, pressed_d;
  logic       key_valid_q, key_valid_d;
  logic       stable_c;

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_RELEASED;
      cand_q       <= '{kind: RES_NONE, code: KEY_NONE};
      stable_cnt_q <= '0;
      key_q        <= KEY_NONE;
      pressed_q    <= 1'b0;
      key_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cand_q       <= cand_d;
      stable_cnt_q <= stable_cnt_d;
      key_q        <= key_d;
      pressed_q    <= pressed_d;
      key_valid_q  <= key_valid_d;
    end
  end

  // Candidate tracking and press/release decision
  always_comb begin
    state_d      = state_q;
    cand_d       = cand_q;
    stable_cnt_d = stable_cnt_q;
    key_d        = key_q;
    pressed_d    = pressed_q;
    key_valid_d  = 1'b0;

    if (strobe_i) begin
      if (res_i == cand_q) begin
        if (stable_cnt_q != SC_W'(DEBOUNCE_FRAMES)) stable_cnt_d = stable_cnt_q + SC_W'(1);
      end else begin
        cand_d       = res_i;
        stable_cnt_d = SC_W'(1);
      end
    end

    // Decision uses the updated count so it fires in the frame that reaches it
    stable_c = strobe_i && (stable_cnt_d == SC_W'(DEBOUNCE_FRAMES));

    case (state_q)
      ST_RELEASED: begin
        if (stable_c && cand_d.kind == RES_SINGLE) begin
          state_d     = ST_PRESSED;
          key_d       = cand_d.code;
          pressed_d   = 1'b1;
          key_valid_d = 1'b1;
        end
      end
      ST_PRESSED: begin
        // Only a stable release leaves PRESSED; no rollover to another key
        if (stable_c && cand_d.kind == RES_NONE) begin
          state_d   = ST_RELEASED;
          key_d     = KEY_NONE;
          pressed_d = 1'b0;
        end
      end
      default: state_d = ST_RELEASED;
    endcase
  end

  assign key_o       = key_q;
  assign pressed_o   = pressed_q;
  assign key_valid_o = key_valid_q;

endmodule

// File: rtl/matrix_key_scan.sv
// 4x4 active-low keypad scanner: row drive, column synchroniser,
// per-frame key accumulation, and debounced key output.
//   clk, rst   : clock, async active-high reset
//   col        : keypad columns, active-low, asynchronous
//   row        : row drive, active-low, one bit low at a time
//   key        : debounced key code, 4'hF when none
//   key_valid  : one-cycle pulse per accepted new press
//   pressed    : high while a debounced key is held
module matrix_key_scan
  import key_pkg::*;
#(
  parameter int unsigned ROW_SETTLE      = 4,
  parameter int unsigned DEBOUNCE_FRAMES = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] col,
  output logic [3:0] row,
  output logic [3:0] key,
  output logic       key_valid,
  output logic       pressed
);

  localparam int unsigned CNT_W = (ROW_SETTLE > 1) ? $clog2(ROW_SETTLE) : 1;

  logic [3:0]       col_meta_q, col_s_q;
  logic [3:0]       row_q, row_d;
  logic [1:0]       row_idx_q, row_idx_d;
  logic [CNT_W-1:0] row_cnt_q, row_cnt_d;
  logic [1:0]       acc_cnt_q, acc_cnt_d;   // low bits seen so far, saturates at 2
  logic [3:0]       acc_code_q, acc_code_d;

  logic [3:0] low_c;
  logic [2:0] samp_n_c, tot_n_c;
  logic [3:0] samp_code_c, tot_code_c;
  logic       row_end_c, frame_end_c;
  frame_res_t frame_res_c;

  // Two-flop column synchroniser
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_meta_q <= 4'hF;
      col_s_q    <= 4'hF;
    end else begin
      col_meta_q <= col;
      col_s_q    <= col_meta_q;
    end
  end

  // Scan counter and frame accumulator registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_q      <= 4'b1110;
      row_idx_q  <= 2'd0;
      row_cnt_q  <= '0;
      acc_cnt_q  <= 2'd0;
      acc_code_q <= KEY_NONE;
    end else begin
      row_q      <= row_d;
      row_idx_q  <= row_idx_d;
      row_cnt_q  <= row_cnt_d;
      acc_cnt_q  <= acc_cnt_d;
      acc_code_q <= acc_code_d;
    end
  end

  // Row sampling, frame result and scan sequencing
  always_comb begin
    row_d      = row_q;
    row_idx_d  = row_idx_q;
    row_cnt_d  = row_cnt_q + CNT_W'(1);
    acc_cnt_d  = acc_cnt_q;
    acc_code_d = acc_code_q;

    row_end_c   = (row_cnt_q == CNT_W'(ROW_SETTLE - 1));
    frame_end_c = row_end_c && (row_idx_q == 2'd3);

    // Unpopulated position (3,3) is masked so it never forms MULTI
    low_c = ~col_s_q;
    if (row_idx_q == 2'd3) low_c[3] = 1'b0;

    samp_n_c    = 3'd0;
    samp_code_c = KEY_NONE;
    for (int unsigned c = 0; c < 4; c++) begin
      if (low_c[c]) begin
        samp_n_c    = samp_n_c + 3'd1;
        samp_code_c = key_code(row_idx_q, 2'(c));
      end
    end

    tot_n_c    = {1'b0, acc_cnt_q} + samp_n_c;
    tot_code_c = (acc_cnt_q != 2'd0) ? acc_code_q : samp_code_c;

    frame_res_c.kind = RES_NONE;
    frame_res_c.code = KEY_NONE;
    if (tot_n_c == 3'd1) begin
      frame_res_c.kind = RES_SINGLE;
      frame_res_c.code = tot_code_c;
    end else if (tot_n_c > 3'd1) begin
      frame_res_c.kind = RES_MULTI;
    end

    if (row_end_c) begin
      row_cnt_d = '0;
      row_d     = {row_q[2:0], row_q[3]};
      row_idx_d = row_idx_q + 2'd1;
      if (frame_end_c) begin
        acc_cnt_d  = 2'd0;
        acc_code_d = KEY_NONE;
      end else begin
        acc_cnt_d  = (tot_n_c > 3'd1) ? 2'd2 : tot_n_c[1:0];
        acc_code_d = tot_code_c;
      end
    end
  end

  key_debounce #(
    .DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)
  ) u_debounce (
    .clk        (clk),
    .rst        (rst),
    .res_i      (frame_res_c),
    .strobe_i   (frame_end_c),
    .key_o      (key),
    .pressed_o  (pressed),
    .key_valid_o(key_valid)
  );

  assign row = row_q;

endmodule

// File: tb/tb_matrix_key_scan.sv
module tb_matrix_key_scan;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  col, row, key;
  logic        key_valid, pressed;
  logic [15:0] keys;   // bit r*4+c set = key (r,c) held down

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  matrix_key_scan dut (
    .clk      (clk),
    .rst      (rst),
    .col      (col),
    .row      (row),
    .key      (key),
    .key_valid(key_valid),
    .pressed  (pressed)
  );

  // Passive keypad: a held key shorts its column low while its row is driven low
  always_comb begin
    col = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !row[r]) col[c] = 1'b0;
  end

  function automatic logic [15:0] kb(input int r, input int c);
    return 16'(1) << (r * 4 + c);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    total++;
    if (act < lo || act > hi) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic run_cycles(input int n, output int pulses);
    pulses = 0;
    repeat (n) begin
      @(negedge clk);
      if (key_valid) pulses++;
    end
  endtask

  // Wait (bounded) until key equals target; returns cycles waited, -1 on timeout
  task automatic wait_key(input logic [3:0] target, input int limit, output int cycles, output int pulses);
    cycles = -1;
    pulses = 0;
    for (int i = 1; i <= limit; i++) begin
      @(negedge clk);
      if (key_valid) pulses++;
      if (key == target) begin
        cycles = i;
        break;
      end
    end
  endtask

  typedef struct {
    logic [15:0] keys;
    int          cycles;
    logic [3:0]  exp_key;
    logic        exp_pressed;
    int          exp_pulses;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs[NV];

  initial begin
    logic [3:0] row_exp[4];
    int pulses, cyc, p2;
    logic [3:0] prev_row;

    vecs[0]  = '{16'h0,                  100, 4'hF, 1'b0, 0};
    vecs[1]  = '{kb(1,1),                150, 4'h5, 1'b1, 1};
    vecs[2]  = '{16'h0,                  100, 4'hF, 1'b0, 0};
    vecs[3]  = '{kb(0,0) | kb(2,2),      150, 4'hF, 1'b0, 0};
    vecs[4]  = '{kb(0,2),                150, 4'h3, 1'b1, 1};
    vecs[5]  = '{kb(0,2) | kb(2,0),      150, 4'h3, 1'b1, 0};
    vecs[6]  = '{16'h0,                  100, 4'hF, 1'b0, 0};
    vecs[7]  = '{kb(0,3),                150, 4'hA, 1'b1, 1};
    vecs[8]  = '{16'h0,                  100, 4'hF, 1'b0, 0};
    vecs[9]  = '{kb(1,3),                150, 4'hB, 1'b1, 1};
    vecs[10] = '{16'h0,                  100, 4'hF, 1'b0, 0};
    vecs[11] = '{kb(3,3),                150, 4'hF, 1'b0, 0};
    vecs[12] = '{kb(3,1),                150, 4'h0, 1'b1, 1};
    vecs[13] = '{16'h0,                  100, 4'hF, 1'b0, 0};

    row_exp[0] = 4'b1110;
    row_exp[1] = 4'b1101;
    row_exp[2] = 4'b1011;
    row_exp[3] = 4'b0111;

    // Reset values
    keys = 16'h0;
    rst  = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_row", int'(row), 4'b1110);
    check("rst_key", int'(key), 4'hF);
    check("rst_valid", int'(key_valid), 0);
    check("rst_pressed", int'(pressed), 0);
    rst = 1'b0;

    // Row sequence, each row held ROW_SETTLE cycles
    for (int n = 0; n < 32; n++) begin
      check("row_seq", int'(row), int'(row_exp[(n / 4) % 4]));
      @(negedge clk);
    end

    // Table-driven key sequences
    for (int v = 0; v < NV; v++) begin
      keys = vecs[v].keys;
      run_cycles(vecs[v].cycles, pulses);
      check($sformatf("vec%0d_key", v), int'(key), int'(vecs[v].exp_key));
      check($sformatf("vec%0d_pressed", v), int'(pressed), int'(vecs[v].exp_pressed));
      check($sformatf("vec%0d_pulses", v), pulses, vecs[v].exp_pulses);
    end

    // Press latency measured from a frame boundary
    prev_row = row;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (row == 4'b1110 && prev_row == 4'b0111) break;
      prev_row = row;
    end
    check("align_boundary", int'(row), 4'b1110);
    keys = kb(1,1);
    wait_key(4'h5, 80, cyc, pulses);
    check("lat_reached", int'(cyc >= 0), 1);
    check_range("press_latency", cyc, 44, 65);
    check("lat_pulse_with_key", int'(key_valid), 1);
    check("lat_pressed", int'(pressed), 1);
    run_cycles(150 - ((cyc > 0) ? cyc : 0), p2);
    check("lat_one_pulse", pulses + p2, 1);
    keys = 16'h0;
    wait_key(4'hF, 90, cyc, pulses);
    check("rel_reached", int'(cyc >= 0), 1);
    check_range("release_latency", cyc, 1, 68);
    check("rel_no_pulse", pulses, 0);
    check("rel_pressed", int'(pressed), 0);
    run_cycles(20, pulses);

    // Bouncing key (2,1): no pulse while bouncing, one pulse once held
    p2 = 0;
    for (int t = 0; t < 8; t++) begin
      keys = keys ^ kb(2,1);
      run_cycles(5, pulses);
      p2 += pulses;
    end
    check("bounce_no_pulse", p2, 0);
    keys = kb(2,1);
    run_cycles(150, pulses);
    check("bounce_settled_pulses", pulses, 1);
    check("bounce_settled_key", int'(key), 4'h8);
    keys = 16'h0;
    run_cycles(100, pulses);
    check("bounce_released", int'(key), 4'hF);

    // Asynchronous reset while a key is held
    keys = kb(0,1);
    wait_key(4'h2, 100, cyc, pulses);
    check("hold_before_rst", int'(key), 4'h2);
    #2 rst = 1'b1;
    #1;
    check("async_rst_key", int'(key), 4'hF);
    check("async_rst_pressed", int'(pressed), 0);
    check("async_rst_row", int'(row), 4'b1110);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    run_cycles(100, pulses);
    check("post_rst_pulses", pulses, 1);
    check("post_rst_key", int'(key), 4'h2);
    check("post_rst_pressed", int'(pressed), 1);
    keys = 16'h0;
    run_cycles(100, pulses);
    check("final_release", int'(key), 4'hF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
